uart_rx_cfg: RTL



---
 rtl/uart_rx_cfg.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// uart_rx_cfg
//   Parametrised UART receiver: DATA_BITS payload bits (5..9), optional
//   odd/even parity, 1 or 2 stop bits. The serial input is brought into the
//   clk domain through a 2-flop synchroniser. A start bit must still be low
//   at its half-bit point, otherwise it is treated as a glitch and ignored.
//   Parity and framing errors are reported with each received frame.
//
// Parameters
//   FREQ       clk frequency in Hz
//   BAUD       line bit rate; FREQ/BAUD must be >= 4
//   DATA_BITS  payload bits per frame (5..9)
//   PARITY     0 = none, 1 = odd, 2 = even
//   STOP_BITS  1 or 2
//
// Ports
//   clk           system clock
//   rst           synchronous, active-high reset
//   in            asynchronous serial line, idle high
//   data          last received payload, LSB = first bit on the line
//   is_receiving  high while a frame is in progress (incl. waiting for idle)
//   is_received   one-cycle pulse: frame complete, data/error flags valid
//   parity_error  parity mismatch of the last frame (always 0 without parity)
//   frame_error   a sampled stop bit of the last frame was 0
// -----------------------------------------------------------------------------
module uart_rx_cfg #(
    parameter int unsigned FREQ      = 50000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in,
    output logic [DATA_BITS-1:0] data,
    output logic                 is_receiving,
    output logic                 is_received,
    output logic                 parity_error,
    output logic                 frame_error
);

    localparam int unsigned CLKS_PER_BIT = FREQ / BAUD;
    localparam int unsigned HALF         = CLKS_PER_BIT / 2;
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    // Expected XOR of payload and parity bit: 1 for odd parity, 0 for even.
    localparam logic          PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t               state;
    logic [1:0]           sync;
    logic                 s_in;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err;
    logic                 frm_err;

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '1;
        end else begin
            sync <= {sync[0], in};
        end
    end

    assign s_in         = sync[1];
    assign is_receiving = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            par_err      <= 1'b0;
            frm_err      <= 1'b0;
            data         <= '0;
            is_received  <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            is_received <= 1'b0;
            case (state)
                IDLE: begin
                    if (!s_in) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end

                // Re-check the line at half a bit; a high level means the
                // falling edge was a glitch. Otherwise restart the counter so
                // every later sample lands on a bit centre.
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (s_in) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            par_err <= 1'b0;
                            frm_err <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // LSB arrives first: shift in at the top so it ends at bit 0.
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shreg <= {s_in, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            state   <= (PARITY != 0) ? PAR : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                PAR: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        par_err <= ((^shreg) ^ s_in) != PAR_ODD;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Frame is published at the centre of the last stop bit so a
                // following start bit with no idle gap is still caught.
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt      <= '0;
                            data         <= shreg;
                            parity_error <= par_err;
                            frame_error  <= frm_err | ~s_in;
                            is_received  <= 1'b1;
                            state        <= (frm_err | ~s_in) ? WAIT_IDLE : IDLE;
                        end else begin
                            frm_err <= frm_err | ~s_in;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // A line held low (break) must not be read as endless frames.
                WAIT_IDLE: begin
                    if (s_in) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
